// File: rtl/uart_alu_intf_if.sv
// uart_alu_intf_if -- bundle of the FIFO handshake and ALU operand/result signals
// for uart_alu_intf.
//   master : the frame controller (pops RX, pushes TX, drives the ALU operands)
//   slave  : the surroundings (RX/TX FIFOs and the combinational ALU)
// Signals:
//   rx_empty   RX FIFO empty            r_data     RX FIFO head byte
//   rd_uart    RX FIFO pop              tx_full    TX FIFO full
//   wr_uart    TX FIFO push             w_data     byte to transmit
//   alu_a/b    operands                 alu_op     opcode
//   alu_result combinational ALU result busy       frame in progress
interface uart_alu_intf_if #(
  parameter int DBIT    = 8,
  parameter int OP_BITS = 6
);
  logic               rx_empty;
  logic [DBIT-1:0]    r_data;
  logic               rd_uart;
  logic               tx_full;
  logic               wr_uart;
  logic [DBIT-1:0]    w_data;
  logic [DBIT-1:0]    alu_a;
  logic [DBIT-1:0]    alu_b;
  logic [OP_BITS-1:0] alu_op;
  logic [DBIT-1:0]    alu_result;
  logic               busy;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/uart_alu_intf.sv
// uart_alu_intf -- collects a three-byte frame (A, B, opcode) from a UART RX
// FIFO, presents it to an external combinational ALU, registers the result and
// pushes it into the UART TX FIFO.
// Ports:
//   clk_sys  system clock
//   rst_b    asynchronous active-low reset
//   bus      uart_alu_intf_if.master (FIFO handshakes, ALU operands/result, busy)
// Build option:
//   UART_ALU_OPCODE_CHECK_EN  when defined, opcodes outside the supported set
//   send ERR_CODE instead of the ALU result; ERR_CODE only exists in that build.
//
// state  | meaning
// GET_A  | idle, waiting for operand A
// GET_B  | waiting for operand B (timeout armed)
// GET_OP | waiting for the opcode (timeout armed)
// EXEC   | one cycle, registers the result byte
// SEND   | waiting for TX FIFO room, pushes the result
module uart_alu_intf #(
  parameter int DBIT     = 8,
  parameter int OP_BITS  = 6,
  parameter int TIMEOUT  = 5_000_000,
  parameter int TMO_BITS = 23
`ifdef UART_ALU_OPCODE_CHECK_EN
  ,
  parameter logic [DBIT-1:0] ERR_CODE = 8'hEE
`endif
) (
  input logic             clk_sys,
  input logic             rst_b,
  uart_alu_intf_if.master bus
);

  localparam logic [2:0] GET_A  = 3'd0;
  localparam logic [2:0] GET_B  = 3'd1;
  localparam logic [2:0] GET_OP = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] SEND   = 3'd4;

  logic [2:0]          state;
  logic [TMO_BITS-1:0] tmo_cnt;
  logic [DBIT-1:0]     a_q;
  logic [DBIT-1:0]     b_q;
  logic [OP_BITS-1:0]  op_q;
  logic [DBIT-1:0]     w_q;
  logic [DBIT-1:0]     exec_byte;
  logic                collecting;
  logic                rd;
  logic                wr;
  logic                tmo_hit;

  assign collecting = (state == GET_A) || (state == GET_B) || (state == GET_OP);
  // Gated by rst_b so no pop is requested while the block is held in reset.
  assign rd      = rst_b && collecting && !bus.rx_empty;
  assign wr      = (state == SEND) && !bus.tx_full;
  assign tmo_hit = (tmo_cnt == TMO_BITS'(TIMEOUT - 1));

`ifdef UART_ALU_OPCODE_CHECK_EN
  logic op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_BITS'(6'h20), OP_BITS'(6'h22), OP_BITS'(6'h24), OP_BITS'(6'h25),
      OP_BITS'(6'h26), OP_BITS'(6'h27), OP_BITS'(6'h03), OP_BITS'(6'h02):
        op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign exec_byte = op_legal ? bus.alu_result : ERR_CODE;
`else
  assign exec_byte = bus.alu_result;
`endif

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state   <= GET_A;
      tmo_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      w_q     <= '0;
    end else begin
      case (state)
        GET_A: begin
          tmo_cnt <= '0;
          if (rd) begin
            a_q   <= bus.r_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (rd) begin
            b_q     <= bus.r_data;
            tmo_cnt <= '0;
            state   <= GET_OP;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= GET_A;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_BITS'(1);
          end
        end
        GET_OP: begin
          if (rd) begin
            op_q    <= bus.r_data[OP_BITS-1:0];
            tmo_cnt <= '0;
            state   <= EXEC;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            state   <= GET_A;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_BITS'(1);
          end
        end
        EXEC: begin
          tmo_cnt <= '0;
          w_q     <= exec_byte;
          state   <= SEND;
        end
        SEND: begin
          tmo_cnt <= '0;
          if (wr) state <= GET_A;
        end
        default: begin
          tmo_cnt <= '0;
          state   <= GET_A;
        end
      endcase
    end
  end

  assign bus.rd_uart = rd;
  assign bus.wr_uart = wr;
  assign bus.w_data  = w_q;
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.alu_op  = op_q;
  assign bus.busy    = (state != GET_A);

endmodule

// File: tb/tb_uart_alu_intf.sv
// tb_uart_alu_intf -- testbench for uart_alu_intf: directed frames with
// hand-computed results plus randomized traffic checked every cycle against a
// frame-level model of the controller.
module tb_uart_alu_intf;
  localparam int DBIT = 8;
  localparam int OP_BITS = 6;
  localparam int TMO = 16;
  localparam logic [7:0] ERR = 8'hEE;

  logic clk_sys = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk_sys = ~clk_sys;

  uart_alu_intf_if #(.DBIT(DBIT), .OP_BITS(OP_BITS)) bus ();

  uart_alu_intf #(
    .DBIT(DBIT), .OP_BITS(OP_BITS), .TIMEOUT(TMO), .TMO_BITS(23)
  ) dut (
    .clk_sys(clk_sys),
    .rst_b(rst_b),
    .bus(bus)
  );

  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return 8'($signed(a) >>> b[2:0]);
      6'h02: return a >> b[2:0];
      default: return a + b + 8'h11;
    endcase
  endfunction

  function automatic bit op_legal(logic [5:0] op);
`ifdef UART_ALU_OPCODE_CHECK_EN
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
`else
    return (op == op);
`endif
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus side: FIFOs and logs ----------------
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int pop_cyc[$];
  int wr_cyc[$];
  logic rd_hist[$];
  logic tx_full_v = 1'b0;
  int cyc = 0;

  task automatic drive();
    bus.rx_empty = (rxq.size() == 0);
    bus.r_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
    bus.tx_full = tx_full_v;
  endtask

  task automatic clear_logs();
    txq.delete();
    pop_cyc.delete();
    wr_cyc.delete();
    rd_hist.delete();
  endtask

  // One clock: sample handshakes mid-cycle, then apply FIFO effects after the edge.
  task automatic step();
    logic pop_now, wr_now;
    logic [7:0] wv;
    @(negedge clk_sys);
    pop_now = bus.rd_uart;
    wr_now = bus.wr_uart;
    wv = bus.w_data;
    rd_hist.push_back(pop_now);
    if (pop_now) pop_cyc.push_back(cyc);
    if (wr_now) begin
      txq.push_back(wv);
      wr_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk_sys);
    #1;
    if (pop_now && rxq.size() > 0) void'(rxq.pop_front());
    drive();
  endtask

  // ---------------- frame-level reference model ----------------
  // m_got: bytes of the current frame accepted (0..2), 3 = computing, 4 = result waiting
  int m_got = 0;
  int m_idle = 0;
  int m_sent = 0;
  logic [7:0] m_a = 0, m_b = 0, m_w = 0;
  logic [5:0] m_op = 0;

  task automatic reset_model();
    m_got = 0;
    m_idle = 0;
    m_a = 0;
    m_b = 0;
    m_op = 0;
    m_w = 0;
  endtask

  always @(posedge clk_sys) begin
    if (rst_b) begin
      if (m_got < 3) begin
        if (!bus.rx_empty) begin
          if (m_got == 0) m_a = bus.r_data;
          else if (m_got == 1) m_b = bus.r_data;
          else m_op = bus.r_data[5:0];
          m_got++;
          m_idle = 0;
        end else if (m_got > 0) begin
          if (m_idle + 1 >= TMO) begin
            m_got = 0;
            m_idle = 0;
          end else begin
            m_idle++;
          end
        end
      end else if (m_got == 3) begin
        m_w = op_legal(m_op) ? alu_fn(m_a, m_b, m_op) : ERR;
        m_got = 4;
      end else if (!bus.tx_full) begin
        m_got = 0;
        m_sent++;
      end
    end
  end

  always @(negedge clk_sys) begin
    logic exp_rd, exp_wr, exp_busy;
    exp_rd = rst_b && (m_got < 3) && !bus.rx_empty;
    exp_wr = (m_got == 4) && !bus.tx_full;
    exp_busy = (m_got != 0);
    check("rd_uart", 32'(bus.rd_uart), 32'(exp_rd));
    check("wr_uart", 32'(bus.wr_uart), 32'(exp_wr));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("alu_a", 32'(bus.alu_a), 32'(m_a));
    check("alu_b", 32'(bus.alu_b), 32'(m_b));
    check("alu_op", 32'(bus.alu_op), 32'(m_op));
    check("w_data", 32'(bus.w_data), 32'(m_w));
  end

  function automatic logic [31:0] tx_at(int i);
    return (txq.size() > i) ? 32'(txq[i]) : 32'hDEAD_BEEF;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic exp_pat[10];
    logic [7:0] legal_ops[8];
    logic [7:0] b;
    int rate;
    legal_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    rst_b = 1'b0;
    tx_full_v = 1'b0;
    reset_model();
    drive();
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rd", 32'(bus.rd_uart), 0);
    check("rst_wr", 32'(bus.wr_uart), 0);
    check("rst_w_data", 32'(bus.w_data), 0);
    rst_b = 1'b1;
    repeat (2) step();

    // Basic add frame and latency from opcode pop to push.
    clear_logs();
    rxq.push_back(8'h05); rxq.push_back(8'h03); rxq.push_back(8'h20);
    drive();
    repeat (6) step();
    check("add_tx_count", txq.size(), 1);
    check("add_w_data", tx_at(0), 8'h08);
    check("add_latency", (wr_cyc.size() > 0 && pop_cyc.size() > 2) ? wr_cyc[0] - pop_cyc[2] : -1, 2);

    // Back-pressure in SEND.
    clear_logs();
    tx_full_v = 1'b1;
    rxq.push_back(8'h07); rxq.push_back(8'h02); rxq.push_back(8'h22);
    drive();
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      check("hold_busy", 32'(bus.busy), 1);
      check("hold_wr", 32'(bus.wr_uart), 0);
      check("hold_w_data", 32'(bus.w_data), 8'h05);
      step();
    end
    check("hold_no_push", txq.size(), 0);
    tx_full_v = 1'b0;
    drive();
    repeat (4) step();
    check("release_count", txq.size(), 1);
    check("release_w_data", tx_at(0), 8'h05);

    // Two queued frames: pop pattern 3 on, 2 off, 3 on.
    clear_logs();
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h24);
    rxq.push_back(8'h0C); rxq.push_back(8'h0A); rxq.push_back(8'h26);
    drive();
    repeat (10) step();
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++)
      check($sformatf("pop_pattern[%0d]", i), (rd_hist.size() > i) ? 32'(rd_hist[i]) : 32'hX, 32'(exp_pat[i]));
    check("pair_count", txq.size(), 2);
    check("pair_w0", tx_at(0), 8'h00);
    check("pair_w1", tx_at(1), 8'h06);

    // Timeout after 16 idle cycles in GET_B, then a clean frame.
    clear_logs();
    rxq.push_back(8'h05);
    drive();
    step();
    repeat (15) step();
    check("tmo_busy_at_15", 32'(bus.busy), 1);
    step();
    check("tmo_busy_at_16", 32'(bus.busy), 0);
    check("tmo_no_push", txq.size(), 0);
    rxq.push_back(8'h09); rxq.push_back(8'h04); rxq.push_back(8'h22);
    drive();
    repeat (6) step();
    check("tmo_next_count", txq.size(), 1);
    check("tmo_next_w_data", tx_at(0), 8'h05);

    // Unsupported opcode.
    clear_logs();
    rxq.push_back(8'h10); rxq.push_back(8'h01); rxq.push_back(8'h3F);
    drive();
    repeat (6) step();
`ifdef UART_ALU_OPCODE_CHECK_EN
    check("bad_op_w_data", tx_at(0), 8'hEE);
`else
    check("bad_op_w_data", tx_at(0), 8'h22);
`endif

    // Reset mid-frame.
    clear_logs();
    rxq.push_back(8'h11);
    drive();
    repeat (2) step();
    check("pre_rst_busy", 32'(bus.busy), 1);
    rxq.push_back(8'h22);
    drive();
    rst_b = 1'b0;
    reset_model();
    #1;
    check("midrst_rd", 32'(bus.rd_uart), 0);
    check("midrst_wr", 32'(bus.wr_uart), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_alu_a", 32'(bus.alu_a), 0);
    check("midrst_w_data", 32'(bus.w_data), 0);
    rxq.delete();
    drive();
    repeat (2) step();
    rst_b = 1'b1;
    rxq.push_back(8'h33); rxq.push_back(8'h44);
    drive();
    repeat (8) step();
    check("postrst_no_push", txq.size(), 0);
    rxq.push_back(8'h20);
    drive();
    repeat (5) step();
    check("postrst_count", txq.size(), 1);
    check("postrst_w_data", tx_at(0), 8'h77);

    // Randomized traffic, alternating dense and sparse arrival to provoke timeouts.
    clear_logs();
    m_sent = 0;
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 0) ? 35 : 5;
      if ($urandom_range(0, 99) < rate) begin
        b = ($urandom_range(0, 1) == 1) ? legal_ops[$urandom_range(0, 7)] : 8'($urandom);
        rxq.push_back(b);
      end
      tx_full_v = ($urandom_range(0, 3) == 0);
      drive();
      step();
    end
    tx_full_v = 1'b0;
    drive();
    repeat (30) step();
    check("rand_push_count", txq.size(), m_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
